// File: rtl/wib_pwr_seq_if.sv
// Control and status bundle between the crate register banks and the
// WIB power sequencer. The register side drives the enables and requests,
// and the sequencer drives the rail, slot, LED and status outputs.
interface wib_pwr_seq_if;
   logic       master_en_in;
   logic [5:0] wib_req_in;
   logic       local_2v5_en_out;
   logic       local_3v3_en_out;
   logic [5:0] wib_en_out;
   logic [5:0] wib_on_led_out;
   logic [2:0] seq_state_out;
   logic       seq_busy_out;

   modport master (
      output master_en_in,
      output wib_req_in,
      input  local_2v5_en_out,
      input  local_3v3_en_out,
      input  wib_en_out,
      input  wib_on_led_out,
      input  seq_state_out,
      input  seq_busy_out
   );

   modport slave (
      input  master_en_in,
      input  wib_req_in,
      output local_2v5_en_out,
      output local_3v3_en_out,
      output wib_en_out,
      output wib_on_led_out,
      output seq_state_out,
      output seq_busy_out
   );
endinterface

// File: rtl/wib_pwr_seq.sv
// WIB crate power sequencer.
// Order of events: 2.5 V rail, then 3.3 V rail, then the WIB slots are
// brought up one at a time with a stagger gap between turn-ons. Dropping
// the master enable tears down the slots and the 3.3 V rail at once, and
// it holds the 2.5 V rail for one more rail dwell before it returns to idle.
module wib_pwr_seq #(
   parameter int unsigned RAIL_CYCLES    = 5000,
   parameter int unsigned STAGGER_CYCLES = 1000,
   parameter int unsigned CNT_W          = 24
) (
   input logic            clk_axi,
   input logic            rstn_axi,
   wib_pwr_seq_if.slave   pwr
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RAIL25   = 3'd1,
      RAIL33   = 3'd2,
      SCAN     = 3'd3,
      STAGGER  = 3'd4,
      SHUTDOWN = 3'd5
   } state_t;

   // A dwell of N cycles loads N-1 and exits on the edge that sees zero.
   // A dwell of zero is stretched to a single cycle.
   localparam int unsigned RAIL_EFF = (RAIL_CYCLES == 0) ? 1 : RAIL_CYCLES;
   localparam int unsigned STAG_EFF = (STAGGER_CYCLES == 0) ? 1 : STAGGER_CYCLES;
   localparam logic [CNT_W-1:0] RAIL_LOAD = CNT_W'(RAIL_EFF - 1);
   localparam logic [CNT_W-1:0] STAG_LOAD = CNT_W'(STAG_EFF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rail25_q, rail25_d;
   logic             rail33_q, rail33_d;
   logic [5:0]       wib_en_q, wib_en_d;
   logic [5:0]       led_q;
   logic [5:0]       cand;
   logic [5:0]       pick;
   logic             dwell_done;
   logic             abort;

   // Pick the lowest requested slot that is not yet powered.
   always_comb begin
      cand = pwr.wib_req_in & ~wib_en_q;
      pick = '0;
      for (int i = 5; i >= 0; i--) begin
         if (cand[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rail25_d   = rail25_q;
      rail33_d   = rail33_q;
      wib_en_d   = wib_en_q;
      dwell_done = (cnt_q == '0);
      abort      = !pwr.master_en_in &&
                   (state_q inside {RAIL25, RAIL33, SCAN, STAGGER});

      if (abort) begin
         state_d  = SHUTDOWN;
         cnt_d    = RAIL_LOAD;
         rail33_d = 1'b0;
         wib_en_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               rail25_d = 1'b0;
               rail33_d = 1'b0;
               wib_en_d = '0;
               if (pwr.master_en_in) begin
                  state_d  = RAIL25;
                  rail25_d = 1'b1;
                  cnt_d    = RAIL_LOAD;
               end
            end
            RAIL25: begin
               if (dwell_done) begin
                  state_d  = RAIL33;
                  rail33_d = 1'b1;
                  cnt_d    = RAIL_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            RAIL33: begin
               if (dwell_done) begin
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            SCAN: begin
               wib_en_d = (wib_en_q & pwr.wib_req_in) | pick;
               if (|pick) begin
                  state_d = STAGGER;
                  cnt_d   = STAG_LOAD;
               end
            end
            STAGGER: begin
               wib_en_d = wib_en_q & pwr.wib_req_in;
               if (dwell_done) begin
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            SHUTDOWN: begin
               if (dwell_done) begin
                  state_d  = IDLE;
                  rail25_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d  = SHUTDOWN;
               cnt_d    = RAIL_LOAD;
               rail33_d = 1'b0;
               wib_en_d = '0;
            end
         endcase
      end
   end

   // State, counter and enable registers. Reset drops every output at once.
   always_ff @(posedge clk_axi or negedge rstn_axi) begin
      if (!rstn_axi) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rail25_q <= 1'b0;
         rail33_q <= 1'b0;
         wib_en_q <= '0;
         led_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rail25_q <= rail25_d;
         rail33_q <= rail33_d;
         wib_en_q <= wib_en_d;
         led_q    <= wib_en_q;
      end
   end

   assign pwr.local_2v5_en_out = rail25_q;
   assign pwr.local_3v3_en_out = rail33_q;
   assign pwr.wib_en_out       = wib_en_q;
   assign pwr.wib_on_led_out   = led_q;
   assign pwr.seq_state_out    = state_q;
   assign pwr.seq_busy_out     = state_q inside {RAIL25, RAIL33, STAGGER, SHUTDOWN};

endmodule

// File: tb/tb_wib_pwr_seq.sv
// Testbench for wib_pwr_seq. It runs two instances, one with short dwells
// and one with zero dwells, under the same stimulus. A deadline-based
// reference model pushes the expected outputs after each edge, and a
// monitor pops and compares those outputs on the falling edge.
module tb_wib_pwr_seq;

   typedef struct packed {
      logic [2:0] st;
      logic       busy;
      logic       r25;
      logic       r33;
      logic [5:0] en;
      logic [5:0] led;
   } obs_t;

   logic clk;
   logic rstn;
   logic       tb_me;
   logic [5:0] tb_req;

   int total = 0;
   int bad   = 0;

   wib_pwr_seq_if bus0 ();
   wib_pwr_seq_if bus1 ();

   wib_pwr_seq #(.RAIL_CYCLES(4), .STAGGER_CYCLES(3), .CNT_W(24)) dut0 (
      .clk_axi  (clk),
      .rstn_axi (rstn),
      .pwr      (bus0.slave)
   );

   wib_pwr_seq #(.RAIL_CYCLES(0), .STAGGER_CYCLES(0), .CNT_W(8)) dut1 (
      .clk_axi  (clk),
      .rstn_axi (rstn),
      .pwr      (bus1.slave)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state. Each dwell is tracked as an absolute edge deadline.
   int         rail_n [2] = '{4, 1};
   int         stag_n [2] = '{3, 1};
   int         m_st   [2];
   longint     m_dl   [2];
   logic       m_r25  [2];
   logic       m_r33  [2];
   logic [5:0] m_en   [2];
   logic [5:0] m_led  [2];
   longint     edge_no = 0;

   obs_t sb0 [$];
   obs_t sb1 [$];

   task automatic model_reset(int d);
      m_st[d]  = 0;
      m_dl[d]  = 0;
      m_r25[d] = 1'b0;
      m_r33[d] = 1'b0;
      m_en[d]  = '0;
      m_led[d] = '0;
   endtask

   task automatic model_step(int d);
      logic [5:0] cand;
      bit         found;
      m_led[d] = m_en[d];
      if (!tb_me && m_st[d] >= 1 && m_st[d] <= 4) begin
         m_st[d]  = 5;
         m_en[d]  = '0;
         m_r33[d] = 1'b0;
         m_dl[d]  = edge_no + rail_n[d];
      end else begin
         case (m_st[d])
            0: if (tb_me) begin
                  m_st[d]  = 1;
                  m_r25[d] = 1'b1;
                  m_dl[d]  = edge_no + rail_n[d];
               end
            1: if (edge_no == m_dl[d]) begin
                  m_st[d]  = 2;
                  m_r33[d] = 1'b1;
                  m_dl[d]  = edge_no + rail_n[d];
               end
            2: if (edge_no == m_dl[d]) m_st[d] = 3;
            3: begin
                  cand    = tb_req & ~m_en[d];
                  m_en[d] = m_en[d] & tb_req;
                  found   = 0;
                  for (int i = 0; i < 6; i++) begin
                     if (!found && cand[i]) begin
                        found      = 1;
                        m_en[d][i] = 1'b1;
                        m_st[d]    = 4;
                        m_dl[d]    = edge_no + stag_n[d];
                     end
                  end
               end
            4: begin
                  m_en[d] = m_en[d] & tb_req;
                  if (edge_no == m_dl[d]) m_st[d] = 3;
               end
            5: if (edge_no == m_dl[d]) begin
                  m_st[d]  = 0;
                  m_r25[d] = 1'b0;
               end
            default: m_st[d] = 5;
         endcase
      end
   endtask

   function automatic obs_t model_obs(int d);
      obs_t o;
      o.st   = 3'(m_st[d]);
      o.busy = (m_st[d] == 1) || (m_st[d] == 2) || (m_st[d] == 4) || (m_st[d] == 5);
      o.r25  = m_r25[d];
      o.r33  = m_r33[d];
      o.en   = m_en[d];
      o.led  = m_led[d];
      return o;
   endfunction

   function automatic obs_t dut_obs(int d);
      obs_t o;
      if (d == 0) begin
         o = {bus0.seq_state_out, bus0.seq_busy_out, bus0.local_2v5_en_out,
              bus0.local_3v3_en_out, bus0.wib_en_out, bus0.wib_on_led_out};
      end else begin
         o = {bus1.seq_state_out, bus1.seq_busy_out, bus1.local_2v5_en_out,
              bus1.local_3v3_en_out, bus1.wib_en_out, bus1.wib_on_led_out};
      end
      return o;
   endfunction

   // Advance the reference model on every edge and queue the expected outputs.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rstn) model_reset(d);
         else       model_step(d);
      end
      sb0.push_back(model_obs(0));
      sb1.push_back(model_obs(1));
      edge_no++;
   end

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: compare each queued expectation on the falling edge.
   initial begin
      obs_t e;
      forever begin
         @(negedge clk);
         while (sb0.size() > 0) begin
            e = sb0.pop_front();
            check_output("dut0 outputs", 32'(dut_obs(0)), 32'(e));
         end
         while (sb1.size() > 0) begin
            e = sb1.pop_front();
            check_output("dut1 outputs", 32'(dut_obs(1)), 32'(e));
         end
      end
   end

   task automatic apply_stimulus(logic me, logic [5:0] req);
      tb_me             = me;
      tb_req            = req;
      bus0.master_en_in = me;
      bus0.wib_req_in   = req;
      bus1.master_en_in = me;
      bus1.wib_req_in   = req;
   endtask

   task automatic wait_edges(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Directed scenarios, then randomized enables and requests.
   initial begin
      rstn = 1'b1;
      apply_stimulus(1'b0, 6'd0);
      #1 rstn = 1'b0;
      #1;
      check_output("reset dut0 outputs zero", 32'(dut_obs(0)), 32'd0);
      check_output("reset dut1 outputs zero", 32'(dut_obs(1)), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;

      @(posedge clk);
      #2 apply_stimulus(1'b1, 6'b000101);
      wait_edges(1);
      check_output("edge0 state", 32'(bus0.seq_state_out), 32'd1);
      check_output("edge0 2v5", 32'(bus0.local_2v5_en_out), 32'd1);
      wait_edges(4);
      check_output("edge4 3v3", 32'(bus0.local_3v3_en_out), 32'd1);
      wait_edges(4);
      check_output("edge8 state scan", 32'(bus0.seq_state_out), 32'd3);
      check_output("edge8 busy", 32'(bus0.seq_busy_out), 32'd0);
      wait_edges(1);
      check_output("edge9 wib_en", 32'(bus0.wib_en_out), 32'h01);
      check_output("edge9 led", 32'(bus0.wib_on_led_out), 32'h00);
      wait_edges(1);
      check_output("edge10 led", 32'(bus0.wib_on_led_out), 32'h01);
      wait_edges(3);
      check_output("edge13 wib_en", 32'(bus0.wib_en_out), 32'h05);
      wait_edges(1);
      check_output("edge14 led", 32'(bus0.wib_on_led_out), 32'h05);

      apply_stimulus(1'b0, 6'b000101);
      wait_edges(1);
      check_output("shutdown state", 32'(bus0.seq_state_out), 32'd5);
      check_output("shutdown wib_en", 32'(bus0.wib_en_out), 32'h00);
      check_output("shutdown 3v3", 32'(bus0.local_3v3_en_out), 32'd0);
      check_output("shutdown 2v5 held", 32'(bus0.local_2v5_en_out), 32'd1);
      apply_stimulus(1'b1, 6'b000101);
      wait_edges(4);
      check_output("shutdown done state", 32'(bus0.seq_state_out), 32'd0);
      check_output("shutdown done 2v5", 32'(bus0.local_2v5_en_out), 32'd0);
      wait_edges(1);
      check_output("restart state", 32'(bus0.seq_state_out), 32'd1);

      wait_edges(10);
      apply_stimulus(1'b1, 6'b000100);
      wait_edges(1);
      check_output("drop in stagger", 32'(bus0.wib_en_out), 32'h00);
      wait_edges(2);
      check_output("bit2 after drop", 32'(bus0.wib_en_out), 32'h04);

      apply_stimulus(1'b0, 6'b000100);
      wait_edges(6);
      apply_stimulus(1'b1, 6'b000101);
      wait_edges(7);
      check_output("mid rail33 state", 32'(bus0.seq_state_out), 32'd2);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check_output("async reset dut0", 32'(dut_obs(0)), 32'd0);
      check_output("async reset dut1", 32'(dut_obs(1)), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rstn = 1'b1;
      wait_edges(1);
      check_output("post reset start", 32'(bus0.seq_state_out), 32'd1);

      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         #2;
         if ($urandom_range(0, 39) == 0) apply_stimulus(~tb_me, tb_req);
         if ($urandom_range(0, 5) == 0) apply_stimulus(tb_me, 6'($urandom_range(0, 63)));
      end

      repeat (2) @(posedge clk);
      @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wib_pwr_seq.md
WIB_PWR_SEQ -- requirements
Module: wib_pwr_seq

Interface
REQ-001 The block SHALL have parameter RAIL_CYCLES, default 5000, setting the dwell in clk_axi cycles between local-rail steps.
REQ-002 The block SHALL have parameter STAGGER_CYCLES, default 1000, setting the minimum gap in clk_axi cycles between successive WIB turn-ons.
REQ-003 The block SHALL have parameter CNT_W, default 24, setting the width of the dwell counter; both cycle parameters SHALL be < 2^CNT_W.
REQ-004 The block SHALL have port clk_axi, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rstn_axi, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port master_en_in, input, 1 bit: crate power master enable, from the RW register bank.
REQ-007 The block SHALL have port wib_req_in, input, 6 bits: per-slot WIB power request, from the RW register bank.
REQ-008 The block SHALL have port local_2v5_en_out, output, 1 bit: local 2.5 V rail enable.
REQ-009 The block SHALL have port local_3v3_en_out, output, 1 bit: local 3.3 V rail enable.
REQ-010 The block SHALL have port wib_en_out, output, 6 bits: per-slot WIB supply enable.
REQ-011 The block SHALL have port wib_on_led_out, output, 6 bits: per-slot front-panel LED.
REQ-012 The block SHALL have port seq_state_out, output, 3 bits: current state encoding, for the RO register bank.
REQ-013 The block SHALL have port seq_busy_out, output, 1 bit: high while a timed step is in progress.

Function
REQ-014 The state machine SHALL have states IDLE=0, RAIL25=1, RAIL33=2, SCAN=3, STAGGER=4, SHUTDOWN=5; codes 6 and 7 SHALL go to SHUTDOWN on the next edge.
REQ-015 IDLE: all enables SHALL be 0; on master_en_in=1, the next edge SHALL enter RAIL25 and set local_2v5_en_out=1.
REQ-016 A dwell state of N cycles entered at edge k SHALL exit at edge k+N; a parameter value of 0 SHALL be treated as 1.
REQ-017 RAIL25 SHALL dwell RAIL_CYCLES, then enter RAIL33 and set local_3v3_en_out=1.
REQ-018 RAIL33 SHALL dwell RAIL_CYCLES, then enter SCAN.
REQ-019 SCAN: on each edge, the block SHALL select the lowest index i with wib_req_in[i]=1 and wib_en_out[i]=0, set wib_en_out[i]=1, and enter STAGGER; if no such i exists, it SHALL stay in SCAN.
REQ-020 STAGGER SHALL dwell STAGGER_CYCLES, then return to SCAN; at most one WIB SHALL turn on per STAGGER window.
REQ-021 In SCAN and STAGGER, wib_req_in[i]=0 SHALL clear wib_en_out[i] on the next edge, with no delay.
REQ-022 A slot that is both a turn-on candidate and dropped in the same cycle SHALL stay off; turn-off SHALL win.
REQ-023 master_en_in=0 in any state other than IDLE or SHUTDOWN SHALL, on the next edge, enter SHUTDOWN and clear all wib_en_out and local_3v3_en_out.
REQ-024 SHUTDOWN SHALL dwell RAIL_CYCLES, then clear local_2v5_en_out and enter IDLE.
REQ-025 master_en_in reasserted during SHUTDOWN SHALL be ignored until IDLE is reached; IDLE SHALL then restart the sequence.
REQ-026 wib_on_led_out SHALL be wib_en_out registered one cycle later.
REQ-027 seq_busy_out SHALL be 1 in RAIL25, RAIL33, STAGGER and SHUTDOWN, and 0 in IDLE and SCAN.
REQ-028 local_3v3_en_out=1 SHALL imply local_2v5_en_out=1, and any wib_en_out bit set SHALL imply local_3v3_en_out=1, on every cycle.

Reset
REQ-029 rstn_axi=0 SHALL immediately force state IDLE and clear the counter and all outputs to 0, including seq_state_out=0 and seq_busy_out=0.
REQ-030 Reset asserted mid-sequence SHALL drop all enables at once, with no shutdown ordering.
REQ-031 After reset deasserts, the first active edge SHALL act as IDLE.

Verification (RAIL_CYCLES=4, STAGGER_CYCLES=3; edge 0 = first edge sampling master_en_in=1)
REQ-032 Power-up: master_en_in=1, wib_req_in=6'b000101 -> 2v5=1 after edge 0, 3v3=1 at edge 4, SCAN at edge 8, wib_en_out=000001 at edge 9, 000101 at edge 13, LEDs one cycle behind.
REQ-033 Drop during stagger: clear wib_req_in[0] at edge 10 -> wib_en_out[0]=0 after edge 11; bit 2 still turns on at edge 13.
REQ-034 Shutdown: master_en_in=0 while 000101 is on -> next edge wib_en_out=0, 3v3=0, state=5; 2v5=0 and state=0 four edges later.
REQ-035 Re-enable during SHUTDOWN: master_en_in pulses back to 1 -> shutdown completes to IDLE, then RAIL25 begins the next edge.
REQ-036 Async reset at edge 6 mid-RAIL33 -> all outputs 0 with no clock edge needed; a new sequence starts cleanly from IDLE.
REQ-037 Zero dwell: RAIL_CYCLES=0 -> each rail step lasts exactly 1 cycle.
